// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// Optional grant statistics are enabled with RR_ARB_STATS_EN.
package rr_onehot_arbiter_pkg;

  localparam int RR_N_DEFAULT = 8;
  localparam int RR_CNT_W     = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // OR-reduce bit positions; exact only for zero/one-hot inputs, which is all the picker produces.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = idx | 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Grant handshake bundle between requesters, arbiter and the downstream encoder.
interface rr_onehot_arbiter_if
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N = RR_N_DEFAULT
);
  logic [N-1:0] req;
  logic [N-1:0] sel;
  logic         sel_valid;
  logic         sel_ready;

  modport master (input req, input sel_ready, output sel, output sel_valid);
  modport slave  (output req, output sel_ready, input sel, input sel_valid);
endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// Combinational round-robin picker: rotate right by ptr, isolate lowest set bit, rotate back.
module rr_onehot_arbiter_pick
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int  N  = RR_N_DEFAULT,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_rot_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_iso;
  logic [2*N-1:0] w_back_dbl;
  logic [4:0]     w_low_idx;

  assign w_rot_dbl  = {i_req, i_req} >> i_ptr;
  assign w_rot      = w_rot_dbl[N-1:0];
  assign w_iso      = w_rot & (~w_rot + N'(1));
  assign w_back_dbl = {w_iso, w_iso} << i_ptr;
  assign o_onehot   = w_back_dbl[2*N-1:N];
  assign w_low_idx  = onehot_to_idx(32'(w_iso));
  // Offset within the rotated frame plus ptr, wrapping naturally since N is a power of 2.
  assign o_idx      = w_low_idx[PW-1:0] + i_ptr;
  assign o_any      = |i_req;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant with valid/ready handshake.
// Define RR_ARB_STATS_EN to add the saturating grant_cnt accepted-grant counter.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N = RR_N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_onehot_arbiter_if.master  bus
`ifdef RR_ARB_STATS_EN
  ,
  output logic [RR_CNT_W-1:0]  grant_cnt
`endif
);

  localparam int PW = $clog2(N);

  arb_state_e    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_idx;
  logic [N-1:0]  r_sel;
  logic          r_sel_valid;

  logic          w_accept;
  logic [PW-1:0] w_next_ptr;
  logic [PW-1:0] w_pick_ptr;
  logic [N-1:0]  w_onehot;
  logic [PW-1:0] w_idx;
  logic          w_any;

  assign w_accept   = r_sel_valid & bus.sel_ready;
  assign w_next_ptr = r_idx + PW'(1);

  // On the accept edge the next winner is chosen against the advanced pointer.
  always_comb begin
    w_pick_ptr = r_ptr;
    if ((r_state == ST_GRANT) && w_accept) begin
      w_pick_ptr = w_next_ptr;
    end else begin
      w_pick_ptr = r_ptr;
    end
  end

  rr_onehot_arbiter_pick #(.N(N)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Grant FSM: registered sel/sel_valid, pointer advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {PW{1'b0}};
      r_idx       <= {PW{1'b0}};
      r_sel       <= {N{1'b0}};
      r_sel_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel       <= w_onehot;
            r_idx       <= w_idx;
            r_sel_valid <= 1'b1;
            r_state     <= ST_GRANT;
          end else begin
            r_sel       <= {N{1'b0}};
            r_sel_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_ptr <= w_next_ptr;
            if (w_any) begin
              r_sel <= w_onehot;
              r_idx <= w_idx;
            end else begin
              r_sel       <= {N{1'b0}};
              r_sel_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_sel       <= r_sel;
            r_sel_valid <= r_sel_valid;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sel       <= {N{1'b0}};
          r_sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;

`ifdef RR_ARB_STATS_EN
  logic [RR_CNT_W-1:0] r_grant_cnt;

  // Saturating count of accepted grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= {RR_CNT_W{1'b0}};
    end else if (w_accept && (r_grant_cnt != {RR_CNT_W{1'b1}})) begin
      r_grant_cnt <= r_grant_cnt + RR_CNT_W'(1);
    end else begin
      r_grant_cnt <= r_grant_cnt;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter, with a small 8-to-3 encoder on sel.
module tb_rr_onehot_arbiter;
  import rr_onehot_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  logic [2:0] code;

  rr_onehot_arbiter_if #(.N(8)) u_if ();

`ifdef RR_ARB_STATS_EN
  logic [15:0] grant_cnt;
`endif

  rr_onehot_arbiter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
`ifdef RR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-to-3 encoder.
  always_comb begin
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (u_if.sel[i]) code = code | 3'(i);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [7:0] s, input logic [2:0] idx);
    check({tag, ".sel"}, 32'(u_if.sel), 32'(s));
    check({tag, ".valid"}, 32'(u_if.sel_valid), 32'(s != 8'h00));
    if (s != 8'h00) check({tag, ".code"}, 32'(code), 32'(idx));
  endtask

  // Structural invariants sampled every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot0", 32'($onehot0(u_if.sel)), 32'd1);
      check("valid_eq_nz", 32'(u_if.sel_valid), 32'(u_if.sel != 8'h00));
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n         = 1'b0;
    u_if.req       = 8'hFF;
    u_if.sel_ready = 1'b0;

    // Reset holds outputs low despite requests.
    @(negedge clk);
    @(negedge clk);
    expect_grant("reset", 8'h00, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_grant("first", 8'h01, 3'd0);

    // Fairness: all requesting, always ready -> rotate one per cycle.
    u_if.sel_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      expect_grant("fair", 8'(8'h01 << (k % 8)), 3'(k % 8));
    end
    u_if.req = 8'h00;
    @(negedge clk);
    expect_grant("fair_idle", 8'h00, 3'd0);

    // Single requester; ptr left at 3 afterwards.
    u_if.req = 8'h04; u_if.sel_ready = 1'b0;
    @(negedge clk);
    expect_grant("single", 8'h04, 3'd2);
    u_if.req = 8'h00; u_if.sel_ready = 1'b1;
    @(negedge clk);
    expect_grant("single_idle", 8'h00, 3'd0);
    u_if.req = 8'hFF; u_if.sel_ready = 1'b0;
    @(negedge clk);
    expect_grant("ptr3", 8'h08, 3'd3);

    // Walk ptr back to 0 by granting bit 7.
    u_if.req = 8'h80; u_if.sel_ready = 1'b1;
    @(negedge clk);
    expect_grant("to7", 8'h80, 3'd7);
    u_if.req = 8'h00;
    @(negedge clk);
    expect_grant("wrap_idle", 8'h00, 3'd0);

    // Backpressure: grant held while not ready, even after req drops.
    u_if.req = 8'h81; u_if.sel_ready = 1'b0;
    @(negedge clk);
    expect_grant("bp_first", 8'h01, 3'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) u_if.req = 8'h00;
      @(negedge clk);
      expect_grant("bp_hold", 8'h01, 3'd0);
    end
    u_if.req = 8'h80; u_if.sel_ready = 1'b1;
    @(negedge clk);
    expect_grant("bp_next", 8'h80, 3'd7);

    // Wrap: after granting bit 6, ptr=7 so req 41 picks bit 0 first.
    u_if.req = 8'h40;
    @(negedge clk);
    expect_grant("wrap_b6", 8'h40, 3'd6);
    u_if.req = 8'h41;
    @(negedge clk);
    expect_grant("wrap_b0", 8'h01, 3'd0);
    @(negedge clk);
    expect_grant("wrap_b6b", 8'h40, 3'd6);
    u_if.req = 8'h00;
    @(negedge clk);
    expect_grant("wrap_end", 8'h00, 3'd0);

    // Async reset between edges drops the in-flight grant at once.
    u_if.req = 8'h10; u_if.sel_ready = 1'b0;
    @(negedge clk);
    expect_grant("pre_rst", 8'h10, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    expect_grant("async_rst", 8'h00, 3'd0);
`ifdef RR_ARB_STATS_EN
    check("cnt_rst", 32'(grant_cnt), 32'd0);
`endif
    @(negedge clk);
    u_if.req = 8'hFF; u_if.sel_ready = 1'b1; rst_n = 1'b1;
    // 21 edges: first loads 01, next 20 each accept and reload.
    for (int k = 0; k < 21; k++) @(negedge clk);
    u_if.sel_ready = 1'b0;
    expect_grant("cnt_seq", 8'h10, 3'd4);
`ifdef RR_ARB_STATS_EN
    check("cnt20", 32'(grant_cnt), 32'd20);
`endif
    @(negedge clk);
    expect_grant("cnt_hold", 8'h10, 3'd4);
`ifdef RR_ARB_STATS_EN
    check("cnt20_hold", 32'(grant_cnt), 32'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
